// File: rtl/inverter_pkg.sv
// Shared definitions for the inverter gate-drive slice: default widths and
// the one-hot state encoding used by the half-bridge dead-time FSM.
package inverter_pkg;

    localparam int DT_W_DEFAULT        = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Bit positions of the one-hot states, so outputs decode straight from a flop.
    localparam int ST_DT_TO_HI_BIT = 1;
    localparam int ST_HI_ON_BIT    = 2;
    localparam int ST_DT_TO_LO_BIT = 3;
    localparam int ST_LO_ON_BIT    = 4;
    localparam int ST_FAULT_BIT    = 5;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_DT_TO_HI = 6'b000010,
        ST_HI_ON    = 6'b000100,
        ST_DT_TO_LO = 6'b001000,
        ST_LO_ON    = 6'b010000,
        ST_FAULT    = 6'b100000
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level input.
// STAGES must be at least 2; the chain clears on reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the chain to settle metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gate_deadtime_driver.sv
// Half-bridge gate driver: turns one PWM bit into complementary high/low
// gate commands with a programmable both-off interval of dead_time+1 cycles
// at every commutation. A synchronized fault latches both gates off until
// acknowledged; enable=0 drops both gates on the next edge.
module gate_deadtime_driver
    import inverter_pkg::*;
#(
    parameter int DT_W        = DT_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            gate_hi,
    output logic            gate_lo,
    output logic            fault_latched,
    output logic            dt_active
);

    state_t          state, state_nxt;
    logic [DT_W-1:0] cnt, cnt_nxt;
    logic            fault_s;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_fault_sync (
        .clk  (clk),
        .reset(reset),
        .d    (fault),
        .q    (fault_s)
    );

    // State and dead-time counter; async reset forces both gates off immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: fault first, then enable, then commutation with dead time.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (fault_s) begin
            state_nxt = ST_FAULT;
        end else if (state == ST_FAULT) begin
            if (fault_clr) begin
                state_nxt = ST_IDLE;
            end
        end else if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = pwm_in ? ST_DT_TO_HI : ST_DT_TO_LO;
                    cnt_nxt   = dead_time;
                end
                ST_HI_ON: begin
                    if (!pwm_in) begin
                        state_nxt = ST_DT_TO_LO;
                        cnt_nxt   = dead_time;
                    end
                end
                ST_LO_ON: begin
                    if (pwm_in) begin
                        state_nxt = ST_DT_TO_HI;
                        cnt_nxt   = dead_time;
                    end
                end
                ST_DT_TO_HI: begin
                    // A reversal retargets without reloading: both gates are already off.
                    if (!pwm_in) begin
                        state_nxt = ST_DT_TO_LO;
                    end else if (cnt == '0) begin
                        state_nxt = ST_HI_ON;
                    end
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_DT_TO_LO: begin
                    if (pwm_in) begin
                        state_nxt = ST_DT_TO_HI;
                    end else if (cnt == '0) begin
                        state_nxt = ST_LO_ON;
                    end
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign gate_hi       = state[ST_HI_ON_BIT];
    assign gate_lo       = state[ST_LO_ON_BIT];
    assign fault_latched = state[ST_FAULT_BIT];
    assign dt_active     = state[ST_DT_TO_HI_BIT] | state[ST_DT_TO_LO_BIT];

endmodule

// File: doc/gate_deadtime_driver.md
# gate_deadtime_driver

Converts the single-ended PWM waveform of the inverter PWM stage into complementary high-side/low-side gate commands for one half-bridge leg. It inserts a programmable dead time at every commutation and hard-disables both gates on enable loss or an external fault. It sits directly downstream of the PWM generator and drives the gate-driver pins.

## Interface
- DT_W, 8, width of dead_time and of the internal dead-time counter
- SYNC_STAGES, 2, flip-flop stages on the asynchronous fault input (minimum 2)

- clk  in  1  system clock, same domain as pwm_in
- reset  in  1  asynchronous, active-high
- enable  in  1  leg enable; 0 forces both gates off
- pwm_in  in  1  registered PWM from upstream; 1 = high side requested
- dead_time  in  DT_W  dead-time setting in clk cycles; both-off interval = dead_time+1
- fault  in  1  asynchronous external fault (desat/overcurrent), active-high
- fault_clr  in  1  single-cycle fault acknowledge
- gate_hi  out  1  high-side gate command
- gate_lo  out  1  low-side gate command
- fault_latched  out  1  1 while in FAULT state
- dt_active  out  1  1 while in either dead-time state

## Operation
- States: IDLE, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON, FAULT.
- All outputs are registered and decoded from the state register:
  - gate_hi=1 only in HI_ON.
  - gate_lo=1 only in LO_ON.
  - dt_active=1 in DT_TO_*.
  - fault_latched=1 in FAULT.
- Invariant: gate_hi and gate_lo are never 1 in the same cycle.
- Priority of transitions, highest first: synchronized fault, then enable=0, then normal flow.
- fault_s (synchronized fault) = 1 from any state -> FAULT.
- FAULT -> IDLE only when fault_clr=1 and fault_s=0. fault_clr while fault_s=1 is ignored.
- enable=0 from any non-FAULT state -> IDLE.
- IDLE, enable=1 -> DT_TO_HI if pwm_in=1, else DT_TO_LO. Load counter with dead_time.
  - A gate can never turn on without a full dead-time interval first.
- HI_ON, pwm_in=0 -> DT_TO_LO, load counter. LO_ON, pwm_in=1 -> DT_TO_HI, load counter.
- DT_TO_x:
  - counter≠0: decrement.
  - counter=0: enter HI_ON or LO_ON per the current target.
- pwm_in reversing during a dead-time state switches the target: DT_TO_HI <-> DT_TO_LO without reloading. The counter keeps running, because both gates are already off.
- dead_time is sampled only at load. Changes mid-count take effect at the next commutation.
- Counter is unsigned DT_W bits. It never wraps: decrement only when ≠0.

## Timing
- Reset values:
  - state=IDLE, counter=0, sync chain=0.
  - gate_hi=0, gate_lo=0, fault_latched=0, dt_active=0.
- Commutation: pwm_in changes, sampled at edge k:
  - edge k: the on gate falls.
  - edge k+dead_time+1: the opposite gate rises.
  - Both-off interval = dead_time+1 cycles (1 cycle when dead_time=0).
- enable=0 sampled at edge k: both gates 0 after edge k (1-cycle latency).
- fault assertion: gates off and fault_latched=1 after SYNC_STAGES+1 edges. This is 3 cycles worst case at the default.
- fault_clr accepted at edge k: IDLE after edge k. If enable=1, DT_TO_x after edge k+1; first gate-on at edge k+dead_time+2.
- Reset asserted mid-operation: both gates 0 immediately (asynchronous), without waiting for a clock edge.
- Simultaneous events:
  - fault_s beats enable and pwm_in.
  - fault_clr with fault_s=1 keeps FAULT.
  - enable=0 in the same cycle as a DT terminal count goes to IDLE.

## Structure
- Shared package inverter_pkg holds:
  - state encoding localparams (one-hot, 6 bits)
  - DT_W default
  - SYNC_STAGES default
- Sub-module sync_ff (parameter STAGES, reset to 0) synchronizes fault. It is reusable for other asynchronous inverter inputs.
- FSM and counter live in gate_deadtime_driver. Estimated at ~150 lines total.

## Test plan
- Commutation timing:
  - stimulus: dead_time=5, enable=1, pwm_in toggling with 40-cycle period
  - required: every edge shows 6 both-off cycles; gate_hi never overlaps gate_lo (assertion over the whole run).
- dead_time=0, pwm_in square wave:
  - required: exactly 1 both-off cycle per edge.
  - corner: dead_time=255 gives 256 cycles.
- Glitch during dead time:
  - stimulus: dead_time=10, pwm_in 0->1, back to 0 three cycles later
  - required: no gate_hi pulse; gate_lo returns 11 cycles after its fall.
- Fault:
  - stimulus: fault pulse asynchronous to clk while HI_ON
  - required: gates 0 and fault_latched=1 within 3 cycles.
  - fault_clr while fault=1: stays in FAULT.
  - fault_clr after fault=0: IDLE, then dead_time+1 both-off cycles before any gate.
- Enable:
  - stimulus: drop enable during LO_ON
  - required: gate_lo=0 next cycle.
  - stimulus: raise enable with pwm_in=1
  - required: gate_hi rises dead_time+1 cycles after DT entry.
- Asynchronous reset:
  - stimulus: reset asserted mid-HI_ON between clock edges
  - required: gate_hi drops without a clock edge; all outputs hold reset values until the first edge after release.
